// File: rtl/seg7_mux_counter_pkg.sv
// seg7_pkg: shared types and constants for the multiplexed seven-segment
// BCD counter.
//   digit_t  - one BCD digit (0..9 held in 4 bits)
//   UI_*     - bit positions of the control inputs inside ui_in
//   seg_of() - BCD digit to segment pattern, bit0 = segment a, active high
package seg7_pkg;

  typedef logic [3:0] digit_t;

  localparam int UI_PAUSE = 0;
  localparam int UI_DOWN  = 1;
  localparam int UI_CLR   = 2;
  localparam int UI_BLANK = 3;

  function automatic logic [6:0] seg_of(input digit_t d);
    logic [6:0] seg;
    case (d)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_mux_counter_if.sv
// seg7_mux_counter_if: the TinyTapeout user pin set minus clock and reset.
//   ena     - design selected (0 behaves as pause)
//   ui_in   - control inputs (pause, direction, clear, blank enable)
//   uio_in  - unused by this design
//   uo_out  - segments a..g in [6:0], decimal point in [7]
//   uio_out - one-hot digit enables
//   uio_oe  - bidirectional pin output enables (constant)
// There is no valid/ready handshake on this bus: every signal is a level,
// inputs are sampled on every rising clock edge and outputs change only on
// rising edges (uio_oe is a constant).
// master = the harness driving the pins, slave = the design.
interface seg7_mux_counter_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
  modport slave  (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/seg7_mux_counter_bcd_digit.sv
// bcd_updown_digit: one BCD up/down digit of a ripple chain.
//   clk, rst_n - clock, asynchronous active-low reset
//   step       - count step for the whole chain this cycle
//   dir        - 0 = up, 1 = down
//   clr        - synchronous clear, wins over step
//   cin        - carry/borrow from the less significant digit
//   value      - current digit (0..9)
//   cout       - carry/borrow into the more significant digit
module bcd_updown_digit
  import seg7_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   step,
  input  logic   dir,
  input  logic   clr,
  input  logic   cin,
  output digit_t value,
  output logic   cout
);

  digit_t val_q;

  // The carry is combinational so a rollover ripples through every digit
  // within the same step cycle.
  always_comb begin
    cout = cin & (dir ? (val_q == 4'd0) : (val_q == 4'd9));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q <= 4'd0;
    end else if (clr) begin
      val_q <= 4'd0;
    end else if (step && cin) begin
      if (dir) begin
        val_q <= (val_q == 4'd0) ? 4'd9 : val_q - 4'd1;
      end else begin
        val_q <= (val_q == 4'd9) ? 4'd0 : val_q + 4'd1;
      end
    end
  end

  assign value = val_q;

endmodule

// File: rtl/seg7_mux_counter.sv
// seg7_mux_counter: DIGITS-digit BCD up/down counter with prescaler, pause,
// synchronous clear and leading-zero blanking, time-multiplexed onto one
// seven-segment bus with one-hot digit enables on uio_out.
//   clk, rst_n - clock, asynchronous active-low reset
//   tt         - pin bundle (seg7_mux_counter_if.slave)
// Parameters: DIGITS (1..8), TICK_DIV (>=2 enabled cycles per step),
// SCAN_DIV (>=2 cycles per digit slot).
module seg7_mux_counter
  import seg7_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 10_000_000,
  parameter int SCAN_DIV = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  seg7_mux_counter_if.slave tt
);

  localparam int P_W = $clog2(TICK_DIV);
  localparam int S_W = $clog2(SCAN_DIV);
  localparam int I_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [P_W-1:0] P_MAX  = P_W'(TICK_DIV - 1);
  localparam logic [S_W-1:0] S_MAX  = S_W'(SCAN_DIV - 1);
  localparam logic [I_W-1:0] I_MAX  = I_W'(DIGITS - 1);
  localparam logic [7:0]     UIO_OE = 8'((9'h1 << DIGITS) - 9'h1);

  logic             cnt_en;
  logic             down_in;
  logic             clr_in;
  logic             blank_in;
  logic             tick;
  logic [P_W-1:0]   p_q;
  logic [S_W-1:0]   s_q;
  logic [I_W-1:0]   idx_q;
  digit_t           cnt [DIGITS];
  logic [DIGITS:0]  carry;
  logic [DIGITS-1:0] blank_vec;
  logic             zero_run;
  digit_t           cur_digit;
  logic [6:0]       seg_next;
  logic             dp_next;
  logic [7:0]       uio_next;
  logic [7:0]       uo_q;
  logic [7:0]       uio_q;

  assign cnt_en   = tt.ena & ~tt.ui_in[UI_PAUSE];
  assign down_in  = tt.ui_in[UI_DOWN];
  assign clr_in   = tt.ui_in[UI_CLR];
  assign blank_in = tt.ui_in[UI_BLANK];

  // A clear on the same edge as the prescaler wrap suppresses the step.
  assign tick = cnt_en & (p_q == P_MAX) & ~clr_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q <= '0;
    end else if (clr_in) begin
      p_q <= '0;
    end else if (cnt_en) begin
      p_q <= (p_q == P_MAX) ? '0 : p_q + 1'b1;
    end
  end

  // Digit chain; digit 0 always receives a carry so step alone moves it.
  assign carry[0] = 1'b1;
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_updown_digit u_digit (
      .clk   (clk),
      .rst_n (rst_n),
      .step  (tick),
      .dir   (down_in),
      .clr   (clr_in),
      .cin   (carry[g]),
      .value (cnt[g]),
      .cout  (carry[g+1])
    );
  end

  // Scan runs free of pause, ena and clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q   <= '0;
      idx_q <= '0;
    end else if (s_q == S_MAX) begin
      s_q   <= '0;
      idx_q <= (idx_q == I_MAX) ? '0 : idx_q + 1'b1;
    end else begin
      s_q <= s_q + 1'b1;
    end
  end

  // Walk down from the top digit: a digit blanks while every digit from the
  // top down to it is zero. Digit 0 never blanks.
  always_comb begin
    zero_run  = 1'b1;
    blank_vec = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run     = zero_run & (cnt[i] == 4'd0);
      blank_vec[i] = blank_in & zero_run;
    end
  end

  // Segment pattern and enable come from the same idx_q and are registered
  // together, so the bus never shows a mismatched digit/segment pair.
  always_comb begin
    cur_digit = cnt[idx_q];
    seg_next  = blank_vec[idx_q] ? 7'h00 : seg_of(cur_digit);
    dp_next   = (idx_q == '0) & ~cnt_en;
    uio_next  = 8'h01 << idx_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uo_q  <= 8'h00;
      uio_q <= 8'h00;
    end else begin
      uo_q  <= {dp_next, seg_next};
      uio_q <= uio_next;
    end
  end

  assign tt.uo_out  = uo_q;
  assign tt.uio_out = uio_q;
  assign tt.uio_oe  = UIO_OE;

  logic unused_bits;
  assign unused_bits = &{1'b0, tt.ui_in[7:4], tt.uio_in, carry[DIGITS]};

endmodule

// File: tb/tb_seg7_mux_counter.sv
module tb_seg7_mux_counter;

  localparam logic [7:0] PAUSE = 8'h01;
  localparam logic [7:0] DOWN  = 8'h02;
  localparam logic [7:0] CLR   = 8'h04;
  localparam logic [7:0] BLANK = 8'h08;

  logic clk;
  logic rst_n;
  seg7_mux_counter_if tt ();

  seg7_mux_counter #(
    .DIGITS   (4),
    .TICK_DIV (4),
    .SCAN_DIV (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tt    (tt)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];     // {uio_out, uo_out} expected per digit slot
  logic        mon_en = 1'b0;
  logic [7:0]  last_uio = 8'h00;

  // Monitor: a new digit slot starts whenever the enable pattern changes.
  always @(negedge clk) begin
    logic [15:0] exp_v;
    if (mon_en && (tt.uio_out != last_uio) && (exp_q.size() > 0)) begin
      exp_v = exp_q.pop_front();
      checks++;
      if ({tt.uio_out, tt.uo_out} != exp_v) begin
        errors++;
        $display("FAIL slot: got uio_out=%h uo_out=%h, expected uio_out=%h uo_out=%h",
                 tt.uio_out, tt.uo_out, exp_v[15:8], exp_v[7:0]);
      end
    end
    last_uio <= tt.uio_out;
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp_v);
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp_v);
    end
  endtask

  // Queue one full frame (digit 0..3) and let the monitor compare it.
  task automatic check_frame(input logic [7:0] d0, input logic [7:0] d1,
                             input logic [7:0] d2, input logic [7:0] d3);
    int n;
    n = 0;
    while (tt.uio_out != 8'h08 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (tt.uio_out != 8'h08) begin
      checks++;
      errors++;
      $display("FAIL frame_sync: uio_out=%h, expected to reach 08", tt.uio_out);
      return;
    end
    @(posedge clk);
    exp_q.push_back({8'h01, d0});
    exp_q.push_back({8'h02, d1});
    exp_q.push_back({8'h04, d2});
    exp_q.push_back({8'h08, d3});
    mon_en = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout: %0d slots not seen, expected 0", exp_q.size());
      exp_q.delete();
    end
    mon_en = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n       = 1'b0;
    tt.ena      = 1'b1;
    tt.ui_in    = 8'h00;
    tt.uio_in   = 8'h00;
    #2;
    check8("reset_uo", tt.uo_out, 8'h00);
    check8("reset_uio", tt.uio_out, 8'h00);
    check8("reset_oe", tt.uio_oe, 8'h0F);

    // Run a little, then reset asynchronously mid-count.
    @(negedge clk);
    rst_n = 1'b1;
    step(6);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check8("async_reset_uo", tt.uo_out, 8'h00);
    check8("async_reset_uio", tt.uio_out, 8'h00);
    check8("async_reset_oe", tt.uio_oe, 8'h0F);

    // Release, counting up from the first edge.
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
    check8("first_slot_uio", tt.uio_out, 8'h01);
    check8("first_slot_uo", tt.uo_out, 8'h3F);
    step(2);                                   // 3 enabled edges: p=3, count 0000
    tt.ui_in = PAUSE;
    check_frame(8'hBF, 8'h3F, 8'h3F, 8'h3F);
    tt.ui_in = 8'h00;
    step(1);                                   // 4th enabled edge: 0001
    tt.ui_in = PAUSE;
    check_frame(8'h86, 8'h3F, 8'h3F, 8'h3F);

    // Carry: 10 ticks from a clear.
    tt.ui_in = PAUSE | CLR;
    step(1);
    tt.ui_in = 8'h00;
    step(40);
    tt.ui_in = PAUSE;
    check_frame(8'hBF, 8'h06, 8'h3F, 8'h3F);   // 0010

    // Down wrap, direction changed mid-interval.
    tt.ui_in = PAUSE | CLR;
    step(1);
    tt.ui_in = 8'h00;
    step(2);
    tt.ui_in = DOWN;
    step(2);
    tt.ui_in = PAUSE | DOWN;
    check_frame(8'hEF, 8'h6F, 8'h6F, 8'h6F);   // 9999
    tt.ui_in = 8'h00;
    step(4);
    tt.ui_in = PAUSE;
    check_frame(8'hBF, 8'h3F, 8'h3F, 8'h3F);   // 0000

    // ena=0 freezes the prescaler like pause.
    tt.ui_in = 8'h00;
    step(2);                                   // p=2
    tt.ena = 1'b0;
    step(40);
    check_frame(8'hBF, 8'h3F, 8'h3F, 8'h3F);
    tt.ena = 1'b1;
    step(1);                                   // p=3, still 0000
    tt.ui_in = PAUSE;
    check_frame(8'hBF, 8'h3F, 8'h3F, 8'h3F);
    tt.ui_in = 8'h00;
    step(1);                                   // tick: 0001
    tt.ui_in = PAUSE;
    check_frame(8'h86, 8'h3F, 8'h3F, 8'h3F);

    // Clear coincident with the tick edge (p=3).
    tt.ui_in = 8'h00;
    step(3);
    tt.ui_in = CLR;
    step(1);
    tt.ui_in = 8'h00;
    step(3);                                   // p=3 again, no tick yet
    tt.ui_in = PAUSE;
    check_frame(8'hBF, 8'h3F, 8'h3F, 8'h3F);
    tt.ui_in = 8'h00;
    step(1);
    tt.ui_in = PAUSE;
    check_frame(8'h86, 8'h3F, 8'h3F, 8'h3F);   // 0001

    // Clear mid-interval (p=2) must zero the prescaler.
    tt.ui_in = 8'h00;
    step(2);
    tt.ui_in = CLR;
    step(1);
    tt.ui_in = 8'h00;
    step(3);
    tt.ui_in = PAUSE;
    check_frame(8'hBF, 8'h3F, 8'h3F, 8'h3F);   // 0000

    // Blanking at 0042.
    tt.ui_in = PAUSE | CLR;
    step(1);
    tt.ui_in = 8'h00;
    step(168);
    tt.ui_in = PAUSE | BLANK;
    check_frame(8'hDB, 8'h66, 8'h00, 8'h00);

    // Blanking at 0100: the inner zero stays lit.
    tt.ui_in = PAUSE | CLR;
    step(1);
    tt.ui_in = 8'h00;
    step(400);
    tt.ui_in = PAUSE | BLANK;
    check_frame(8'hBF, 8'h3F, 8'h06, 8'h00);

    // Blanking at 0000 while running (clear held).
    tt.ui_in = CLR | BLANK;
    step(1);
    check_frame(8'h3F, 8'h00, 8'h00, 8'h00);

    step(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
